// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-addressed memory between instruction fetch and
// load/store, one access in flight, with a watchdog that aborts hung memory accesses.
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDRSIZE-1:0]   if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WIDTH-1:0]      if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WIDTH/8-1:0]    d_be,
    input  logic [ADDRSIZE-1:0]   d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH/8-1:0]    mem_be,
    output logic [ADDRSIZE-1:0]   mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic             win_d;
    logic             last_d;
    logic [CNT_W-1:0] wdog_cnt;
    logic             d_win;
    logic             if_win;

    // Returned word: stores and aborted accesses always report zero.
    function automatic logic [WIDTH-1:0] rd_result(input logic we, input logic abort,
                                                   input logic [WIDTH-1:0] data);
        return (we || abort) ? '0 : data;
    endfunction

    // On a conflict the port that lost the previous grant goes first.
    assign d_win  = d_req && (!if_req || !last_d);
    assign if_win = if_req && !d_win;
    assign if_gnt = !rst && (state == IDLE) && if_win;
    assign d_gnt  = !rst && (state == IDLE) && d_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_d     <= 1'b0;
            last_d    <= 1'b0;
            wdog_cnt  <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state    <= BUSY;
                        win_d    <= d_win;
                        last_d   <= d_win;
                        mem_req  <= 1'b1;
                        wdog_cnt <= '0;
                        if (d_win) begin
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack || (TIMEOUT > 0 && wdog_cnt == TO_LAST)) begin
                        // An ack in the final watchdog cycle still counts as a normal completion.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        err     <= !mem_ack;
                        if (win_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= rd_result(mem_we, !mem_ack, mem_rdata);
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= rd_result(1'b0, !mem_ack, mem_rdata);
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; the bench plays both requesters
// and the memory, predicting each access from a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [11:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [0:4095];
    bit          exp_last_d;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;

    mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req), 32'd0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_d_rvalid"},  32'(d_rvalid), 32'd0);
        chk({tag, "_err"},       32'(err), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_quiet("rst");
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_last_d = 1'b0;
        exp_if_rd  = '0;
        exp_d_rd   = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ack();
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        #1;
        chk("idle_if_gnt", 32'(if_gnt), 32'd0);
        chk("idle_d_gnt", 32'(d_gnt), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk_quiet("idle_ack");
        chk("idle_if_rdata", if_rdata, exp_if_rd);
        chk("idle_d_rdata", d_rdata, exp_d_rd);
    endtask

    // One request round. ackc = BUSY cycle (1-based) in which memory acks; 0 or >TO = never.
    task automatic xact(input bit ir, input bit dr, input bit we, input logic [3:0] be,
                        input logic [11:0] ia, input logic [11:0] da,
                        input logic [31:0] wd, input int ackc);
        bit          dwin;
        bit          acked;
        logic [11:0] a;
        logic [31:0] res;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
        #1;
        dwin = dr && (!ir || !exp_last_d);
        chk("if_gnt", 32'(if_gnt), 32'(ir && !dwin));
        chk("d_gnt", 32'(d_gnt), 32'(dwin));
        if (!ir && !dr) begin
            @(posedge clk);
            #1;
            chk("noreq_mem_req", 32'(mem_req), 32'd0);
            return;
        end
        exp_last_d = dwin;
        a     = dwin ? da : ia;
        res   = '0;
        acked = 1'b0;
        @(posedge clk);
        #1;
        if (dwin) d_req = 1'b0; else if_req = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            chk("busy_mem_req", 32'(mem_req), 32'd1);
            chk("busy_mem_addr", 32'(mem_addr), 32'(a));
            chk("busy_mem_we", 32'(mem_we), 32'(dwin && we));
            chk("busy_mem_be", 32'(mem_be), 32'(dwin ? be : 4'hf));
            if (dwin && we) chk("busy_mem_wdata", mem_wdata, wd);
            chk("busy_if_gnt", 32'(if_gnt), 32'd0);
            chk("busy_d_gnt", 32'(d_gnt), 32'd0);
            chk("busy_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("busy_d_rvalid", 32'(d_rvalid), 32'd0);
            if (k == ackc) begin
                mem_ack = 1'b1;
                acked   = 1'b1;
                if (dwin && we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_model[a][8*b +: 8] = wd[8*b +: 8];
                    mem_rdata = $urandom;
                end else begin
                    res       = mem_model[a];
                    mem_rdata = res;
                end
            end else begin
                mem_rdata = $urandom;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (acked) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        if (dwin) exp_d_rd = res; else exp_if_rd = res;
        chk("done_if_rvalid", 32'(if_rvalid), 32'(!dwin));
        chk("done_d_rvalid", 32'(d_rvalid), 32'(dwin));
        chk("done_err", 32'(err), 32'(!acked));
        chk("done_if_rdata", if_rdata, exp_if_rd);
        chk("done_d_rdata", d_rdata, exp_d_rd);
        chk("done_mem_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = $urandom;
        mem_model[12'h010] = 32'h00A00093;
        exp_last_d = 1'b0;
        exp_if_rd  = '0;
        exp_d_rd   = '0;

        do_reset();

        // Fetch only, single-cycle memory
        xact(1'b1, 1'b0, 1'b0, 4'h0, 12'h010, 12'h000, 32'h0, 1);
        chk("t1_if_rdata", if_rdata, 32'h00A00093);

        // Conflict after reset: data first, then alternation
        do_reset();
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h003, 12'h004, 32'h0, 1);
        chk("t2_first_winner_d", 32'(exp_last_d), 32'd1);
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h003, 12'h005, 32'h0, 1);
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h006, 12'h007, 32'h0, 1);
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h008, 12'h009, 32'h0, 1);

        // Byte store, then read it back
        xact(1'b0, 1'b1, 1'b1, 4'b0001, 12'h000, 12'h100, 32'h000000FF, 1);
        chk("t3_store_rdata", d_rdata, 32'd0);
        xact(1'b0, 1'b1, 1'b0, 4'hf, 12'h000, 12'h100, 32'h0, 2);

        // Slow memory, ack in sixth BUSY cycle
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h00A, 12'h00B, 32'h0, 6);

        // Watchdog: no ack, then ack exactly on the last allowed cycle
        xact(1'b1, 1'b0, 1'b0, 4'hf, 12'h00C, 12'h000, 32'h0, 0);
        xact(1'b0, 1'b1, 1'b0, 4'hf, 12'h000, 12'h00D, 32'h0, TO);
        xact(1'b0, 1'b1, 1'b1, 4'hf, 12'h000, 12'h00E, 32'h12345678, 0);

        // Ack while idle is ignored
        idle_ack();

        // Reset during a busy fetch
        if_req  = 1'b1;
        if_addr = 12'h020;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        chk("t6_busy", 32'(mem_req), 32'd1);
        #2;
        do_reset();
        idle_ack();
        xact(1'b1, 1'b1, 1'b0, 4'hf, 12'h011, 12'h012, 32'h0, 1);
        chk("t6_data_first", 32'(exp_last_d), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            int ackc;
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) ackc = 0;
            else if (r < 3) ackc = int'($urandom_range(1, TO + 2));
            else ackc = int'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) idle_ack();
            xact(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                 12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)), $urandom, ackc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
